prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Boot-time program loader for the SAP-2 datapath. It takes a byte stream over a valid/ready port and writes it into main memory by sequencing the shared 16-bit bus, MAR load, MDR bus-load and RAM write strobes. It holds the CPU in reset while loading. It sits beside the control unit; the top level muxes its bus drive and memory strobes onto the datapath while cpu_hold=1.

Parameters:
TIMEOUT, 1_000_000, idle-stream cycles tolerated in HDR/DWAIT before error; 0 disables the timeout
CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  system clock (divided CPU clock domain)
rst  in  1  asynchronous, active-low reset
start  in  1  begin load; sampled in IDLE only
in_data  in  8  stream byte
in_valid  in  1  stream byte valid
in_ready  out  1  loader accepts byte; transfer when in_valid&in_ready at rising clk
cpu_hold  out  1  holds CPU/control unit in reset; grants loader the bus and memory strobes
bus_req  out  1  loader drives bus_out onto the bus this cycle
bus_out  out  16  bus drive value
mar_load  out  1  MAR load strobe
mdr_load_bus  out  1  MDR load-from-bus strobe
ram_write  out  1  RAM write strobe
busy  out  1  load in progress
done  out  1  one-cycle pulse on successful completion
err  out  1  sticky timeout error
bytes_written  out  16  count of RAM writes in the current/last load

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; address, length, byte and timeout registers 0.
- Stream format: addr_lo, addr_hi, len_lo, len_hi, then len data bytes. Address and length are 16-bit little-endian.
- States: IDLE, HDR, DWAIT, SET_MAR, SET_MDR, WRITE, FINISH, ERROR. Strobes decode from registered state (Moore).
- IDLE: in_ready=0. On start=1: clear err and bytes_written, hdr_idx=0, go to HDR.
- HDR: in_ready=1, busy=1. Each handshake stores a byte at hdr_idx, then hdr_idx+1. After the 4th byte: go to FINISH if len==0, else DWAIT.
- DWAIT: in_ready=1. On handshake, latch byte and go to SET_MAR.
- SET_MAR: bus_req=1, bus_out=addr, mar_load=1.
- SET_MDR: bus_req=1, bus_out={8'h00,byte}, mdr_load_bus=1.
- WRITE: ram_write=1, bus_req=0. On exit: addr+1 (wraps 16'hFFFF->16'h0000), remaining-1, bytes_written+1. Go to FINISH if remaining was 1, else DWAIT.
- Throughput: 4 cycles per byte minimum (DWAIT handshake + 3 write cycles).
- FINISH: done=1 for exactly one cycle, busy=1, then IDLE.
- busy=1 in all states except IDLE and ERROR.
- cpu_hold = busy | err. It rises the cycle after start is accepted and drops on entry to IDLE after FINISH.
- Timeout (TIMEOUT>0): counter runs in HDR/DWAIT while no handshake, and clears on handshake or state change. On reaching TIMEOUT, go to ERROR.
- ERROR: err=1 for one cycle, then IDLE with err still 1, so cpu_hold stays asserted. err clears only on the next accepted start or on reset.
- start while busy: ignored. in_valid outside HDR/DWAIT: ignored, no handshake.
- Reset mid-load: immediate return to IDLE with all strobes 0. Partially written memory is not rolled back.
- At most one of mar_load/mdr_load_bus/ram_write is high in any cycle. bus_req=1 only in SET_MAR and SET_MDR.

Test Plan:
- Basic load: start; stream 10 00 03 00 AA BB CC -> MAR loaded with 0x0010/0x0011/0x0012, MDR 0x00AA/0x00BB/0x00CC, 3 ram_write pulses, done pulse, bytes_written=3, cpu_hold low after done.
- Zero length: stream 00 01 00 00 -> no mar_load/ram_write, done pulses one cycle after 4th header byte, bytes_written=0.
- Wrap + backpressure: addr FFFF, len 2, in_valid toggled every other cycle -> writes at 0xFFFF then 0x0000; handshakes only while in_ready=1; no byte lost or duplicated.
- Timeout: TIMEOUT=16; send 2 header bytes then stall -> ERROR 16 cycles after last handshake, err=1, cpu_hold stays 1; a new start clears err.
- Reset mid-load: assert rst low during SET_MDR of byte 2 -> all outputs 0 asynchronously, state IDLE; a following full load completes normally.
- start pulsed during DWAIT: no restart, header unchanged, load completes with original address and length.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time program loader for the SAP-2 datapath.
// Accepts a little-endian header (addr, len) followed by len data bytes
// on a valid/ready stream. Each byte goes into main memory through a
// MAR load, an MDR bus load and a RAM write. The CPU is held in reset
// while a load is in progress or after a timeout error.
module prog_loader #(
  parameter int unsigned TIMEOUT = 1_000_000,
  parameter int unsigned CNT_W   = 20
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic        cpu_hold_o,
  output logic        bus_req_o,
  output logic [15:0] bus_out_o,
  output logic        mar_load_o,
  output logic        mdr_load_bus_o,
  output logic        ram_write_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] bytes_written_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DWAIT,
    S_SET_MAR,
    S_SET_MDR,
    S_WRITE,
    S_FINISH,
    S_ERROR
  } state_e;

  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT);
  localparam bit               TMO_EN  = (TIMEOUT != 0);

  state_e            state_q, state_d;
  logic [1:0]        hdr_idx_q, hdr_idx_d;
  logic [15:0]       addr_q, addr_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        byte_q, byte_d;
  logic [15:0]       bw_q, bw_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic              hs;
  logic              stalled;

  // A byte transfers only while the loader is listening for one.
  assign hs      = in_ready_o & in_valid_i;
  assign stalled = TMO_EN && ((tmo_q + CNT_W'(1)) == TMO_LIM);

  // State and datapath registers; reset abandons any load in progress.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      hdr_idx_q <= 2'd0;
      addr_q    <= 16'h0000;
      len_q     <= 16'h0000;
      byte_q    <= 8'h00;
      bw_q      <= 16'h0000;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      hdr_idx_q <= hdr_idx_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      byte_q    <= byte_d;
      bw_q      <= bw_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  // Next-state logic; the idle counter defaults to zero so any handshake
  // or state change clears it.
  always_comb begin
    state_d   = state_q;
    hdr_idx_d = hdr_idx_q;
    addr_d    = addr_q;
    len_d     = len_q;
    byte_d    = byte_q;
    bw_d      = bw_q;
    err_d     = err_q;
    tmo_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          err_d     = 1'b0;
          bw_d      = 16'h0000;
          hdr_idx_d = 2'd0;
          state_d   = S_HDR;
        end
      end
      S_HDR: begin
        if (hs) begin
          case (hdr_idx_q)
            2'd0:    addr_d[7:0]  = in_data_i;
            2'd1:    addr_d[15:8] = in_data_i;
            2'd2:    len_d[7:0]   = in_data_i;
            default: len_d[15:8]  = in_data_i;
          endcase
          hdr_idx_d = hdr_idx_q + 2'd1;
          if (hdr_idx_q == 2'd3) begin
            state_d = ({in_data_i, len_q[7:0]} == 16'h0000) ? S_FINISH : S_DWAIT;
          end
        end else if (stalled) begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end else if (TMO_EN) begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      S_DWAIT: begin
        if (hs) begin
          byte_d  = in_data_i;
          state_d = S_SET_MAR;
        end else if (stalled) begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end else if (TMO_EN) begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      S_SET_MAR: state_d = S_SET_MDR;
      S_SET_MDR: state_d = S_WRITE;
      S_WRITE: begin
        addr_d  = addr_q + 16'd1;
        len_d   = len_q - 16'd1;
        bw_d    = bw_q + 16'd1;
        state_d = (len_q == 16'd1) ? S_FINISH : S_DWAIT;
      end
      S_FINISH: state_d = S_IDLE;
      S_ERROR:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore output decode: strobes and bus drive follow the registered state.
  always_comb begin
    in_ready_o     = 1'b0;
    busy_o         = 1'b0;
    bus_req_o      = 1'b0;
    bus_out_o      = 16'h0000;
    mar_load_o     = 1'b0;
    mdr_load_bus_o = 1'b0;
    ram_write_o    = 1'b0;
    done_o         = 1'b0;
    case (state_q)
      S_HDR, S_DWAIT: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b1;
      end
      S_SET_MAR: begin
        busy_o     = 1'b1;
        bus_req_o  = 1'b1;
        bus_out_o  = addr_q;
        mar_load_o = 1'b1;
      end
      S_SET_MDR: begin
        busy_o         = 1'b1;
        bus_req_o      = 1'b1;
        bus_out_o      = {8'h00, byte_q};
        mdr_load_bus_o = 1'b1;
      end
      S_WRITE: begin
        busy_o      = 1'b1;
        ram_write_o = 1'b1;
      end
      S_FINISH: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign err_o           = err_q;
  assign cpu_hold_o      = busy_o | err_q;
  assign bytes_written_o = bw_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader. A negedge monitor models
// the external MAR/MDR/RAM and logs strobes and handshakes; each test task
// compares those logs and the outputs against hand-computed values.
module tb_prog_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  inData;
  logic        inValid;
  logic        inReady;
  logic        cpuHold;
  logic        busReq;
  logic [15:0] busOut;
  logic        marLoad;
  logic        mdrLoadBus;
  logic        ramWrite;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] bytesWritten;

  int checks = 0;
  int errors = 0;

  logic [15:0] marLog[$];
  logic [15:0] mdrLog[$];
  logic [15:0] wrAddrLog[$];
  logic [7:0]  wrDataLog[$];
  logic [7:0]  hsLog[$];
  int          doneCount;
  logic [15:0] modelMar;
  logic [15:0] modelMdr;

  prog_loader #(
    .TIMEOUT(16),
    .CNT_W  (5)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .in_data_i      (inData),
    .in_valid_i     (inValid),
    .in_ready_o     (inReady),
    .cpu_hold_o     (cpuHold),
    .bus_req_o      (busReq),
    .bus_out_o      (busOut),
    .mar_load_o     (marLoad),
    .mdr_load_bus_o (mdrLoadBus),
    .ram_write_o    (ramWrite),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .bytes_written_o(bytesWritten)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Models the external MAR/MDR/RAM and checks strobe exclusivity each cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (inValid && inReady) hsLog.push_back(inData);
      if (marLoad) begin
        marLog.push_back(busOut);
        modelMar = busOut;
      end
      if (mdrLoadBus) begin
        mdrLog.push_back(busOut);
        modelMdr = busOut;
      end
      if (ramWrite) begin
        wrAddrLog.push_back(modelMar);
        wrDataLog.push_back(modelMdr[7:0]);
      end
      if (done) doneCount++;
      checks++;
      if ((int'(marLoad) + int'(mdrLoadBus) + int'(ramWrite)) > 1) begin
        errors++;
        $display("[TB] FAIL strobe_onehot: mar=%b mdr=%b ram=%b, required at most one", marLoad, mdrLoadBus, ramWrite);
      end
      checks++;
      if (busReq !== (marLoad | mdrLoadBus)) begin
        errors++;
        $display("[TB] FAIL bus_req: got %b, required %b", busReq, marLoad | mdrLoadBus);
      end
    end
  end

  // Global watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clearLogs();
    marLog.delete();
    mdrLog.delete();
    wrAddrLog.delete();
    wrDataLog.delete();
    hsLog.delete();
    doneCount = 0;
  endtask

  // Called at posedge+1 in IDLE; leaves the DUT in HDR at posedge+1.
  task automatic doStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers one byte and returns at posedge+1 just after it is accepted.
  task automatic sendByte(input logic [7:0] b);
    int cnt;
    cnt = 0;
    inData = b;
    inValid = 1'b1;
    @(negedge clk);
    while (!inReady && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (!inReady) begin
      errors++;
      $display("[TB] FAIL handshake_timeout: byte %h not accepted, in_ready=%b, required 1", b, inReady);
    end
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  // Waits up to budget cycles for done; returns at the negedge where done is high.
  task automatic waitDone(input int budget);
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (!done && cnt < budget) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL done_timeout: done=%b after %0d cycles, required 1", done, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    inData = 8'h00;
    inValid = 1'b0;
    #23;
    checks++;
    if ({inReady, cpuHold, busReq, busOut, marLoad, mdrLoadBus, ramWrite, busy, done, err, bytesWritten} !== 42'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h, required 0",
               {inReady, cpuHold, busReq, busOut, marLoad, mdrLoadBus, ramWrite, busy, done, err, bytesWritten});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_load();
    logic [15:0] expMar[3];
    logic [15:0] expMdr[3];
    expMar = '{16'h0010, 16'h0011, 16'h0012};
    expMdr = '{16'h00AA, 16'h00BB, 16'h00CC};
    $display("[TB] basic load");
    clearLogs();
    doStart();
    checks++;
    if (cpuHold !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_after_start: cpu_hold=%b busy=%b, required 1 1", cpuHold, busy);
    end
    sendByte(8'h10); sendByte(8'h00); sendByte(8'h03); sendByte(8'h00);
    sendByte(8'hAA); sendByte(8'hBB); sendByte(8'hCC);
    waitDone(20);
    checks++;
    if (bytesWritten !== 16'd3) begin
      errors++;
      $display("[TB] FAIL basic_bytes_written: got %0d, required 3", bytesWritten);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (cpuHold !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_after_done: cpu_hold=%b done=%b busy=%b, required 0 0 0", cpuHold, done, busy);
    end
    checks++;
    if (marLog.size() != 3 || mdrLog.size() != 3 || wrAddrLog.size() != 3) begin
      errors++;
      $display("[TB] FAIL basic_strobe_counts: mar=%0d mdr=%0d wr=%0d, required 3 3 3", marLog.size(), mdrLog.size(), wrAddrLog.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= marLog.size() || marLog[i] !== expMar[i] || i >= mdrLog.size() || mdrLog[i] !== expMdr[i]) begin
        errors++;
        $display("[TB] FAIL basic_write_%0d: mar=%h mdr=%h, required %h %h", i,
                 (i < marLog.size()) ? marLog[i] : 16'hxxxx, (i < mdrLog.size()) ? mdrLog[i] : 16'hxxxx, expMar[i], expMdr[i]);
      end
    end
    checks++;
    if (doneCount != 1) begin
      errors++;
      $display("[TB] FAIL basic_done_pulses: got %0d, required 1", doneCount);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_length();
    $display("[TB] zero length");
    clearLogs();
    doStart();
    sendByte(8'h00); sendByte(8'h01); sendByte(8'h00); sendByte(8'h00);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || bytesWritten !== 16'd0) begin
      errors++;
      $display("[TB] FAIL zero_done: done=%b bytes_written=%0d, required 1 0", done, bytesWritten);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cpuHold !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_after: done=%b cpu_hold=%b, required 0 0", done, cpuHold);
    end
    checks++;
    if (marLog.size() != 0 || wrAddrLog.size() != 0 || doneCount != 1) begin
      errors++;
      $display("[TB] FAIL zero_no_writes: mar=%0d wr=%0d done=%0d, required 0 0 1", marLog.size(), wrAddrLog.size(), doneCount);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap_backpressure();
    logic [7:0]  stream[6];
    logic [15:0] expAddr[2];
    logic [7:0]  expData[2];
    int idx;
    int cyc;
    stream  = '{8'hFF, 8'hFF, 8'h02, 8'h00, 8'h11, 8'h22};
    expAddr = '{16'hFFFF, 16'h0000};
    expData = '{8'h11, 8'h22};
    $display("[TB] wrap and backpressure");
    clearLogs();
    doStart();
    idx = 0;
    cyc = 0;
    while (idx < 6 && cyc < 300) begin
      inValid = cyc[0];
      inData = stream[idx];
      @(negedge clk);
      if (inValid && inReady) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    inValid = 1'b0;
    checks++;
    if (idx != 6) begin
      errors++;
      $display("[TB] FAIL wrap_stream: accepted %0d bytes, required 6", idx);
    end
    waitDone(20);
    checks++;
    if (bytesWritten !== 16'd2) begin
      errors++;
      $display("[TB] FAIL wrap_bytes_written: got %0d, required 2", bytesWritten);
    end
    @(posedge clk); #1;
    checks++;
    if (hsLog.size() != 6) begin
      errors++;
      $display("[TB] FAIL wrap_hs_count: got %0d, required 6", hsLog.size());
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= hsLog.size() || hsLog[i] !== stream[i]) begin
        errors++;
        $display("[TB] FAIL wrap_hs_%0d: got %h, required %h", i, (i < hsLog.size()) ? hsLog[i] : 8'hxx, stream[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= wrAddrLog.size() || wrAddrLog[i] !== expAddr[i] || wrDataLog[i] !== expData[i]) begin
        errors++;
        $display("[TB] FAIL wrap_write_%0d: addr=%h data=%h, required %h %h", i,
                 (i < wrAddrLog.size()) ? wrAddrLog[i] : 16'hxxxx, (i < wrDataLog.size()) ? wrDataLog[i] : 8'hxx, expAddr[i], expData[i]);
      end
    end
  endtask

  task automatic test_start_in_dwait();
    $display("[TB] start during DWAIT");
    clearLogs();
    doStart();
    sendByte(8'h30); sendByte(8'h00); sendByte(8'h02); sendByte(8'h00);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || inReady !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dwait_start_ignored: busy=%b in_ready=%b, required 1 1", busy, inReady);
    end
    sendByte(8'h66);
    sendByte(8'h77);
    waitDone(20);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bytesWritten !== 16'd2 || doneCount != 1) begin
      errors++;
      $display("[TB] FAIL dwait_complete: busy=%b bytes_written=%0d done=%0d, required 0 2 1", busy, bytesWritten, doneCount);
    end
    checks++;
    if (marLog.size() != 2 || marLog[0] !== 16'h0030 || marLog[1] !== 16'h0031) begin
      errors++;
      $display("[TB] FAIL dwait_addresses: count=%0d, required 2 writes at 0030 0031", marLog.size());
    end
    checks++;
    if (mdrLog.size() != 2 || mdrLog[0] !== 16'h0066 || mdrLog[1] !== 16'h0077) begin
      errors++;
      $display("[TB] FAIL dwait_data: count=%0d, required 0066 0077", mdrLog.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midload();
    $display("[TB] reset mid-load");
    clearLogs();
    doStart();
    sendByte(8'h20); sendByte(8'h00); sendByte(8'h03); sendByte(8'h00);
    sendByte(8'h01);
    sendByte(8'h02);
    @(posedge clk); #1;
    checks++;
    if (mdrLoadBus !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midload_in_set_mdr: mdr_load_bus=%b, required 1", mdrLoadBus);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({inReady, cpuHold, busReq, busOut, marLoad, mdrLoadBus, ramWrite, busy, done, err, bytesWritten} !== 42'd0) begin
      errors++;
      $display("[TB] FAIL midload_reset_outputs: got %h, required 0",
               {inReady, cpuHold, busReq, busOut, marLoad, mdrLoadBus, ramWrite, busy, done, err, bytesWritten});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || inReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midload_idle: busy=%b in_ready=%b, required 0 0", busy, inReady);
    end
    clearLogs();
    doStart();
    sendByte(8'h40); sendByte(8'h00); sendByte(8'h02); sendByte(8'h00);
    sendByte(8'h5A); sendByte(8'hA5);
    waitDone(20);
    checks++;
    if (bytesWritten !== 16'd2 || wrAddrLog.size() != 2 || wrAddrLog[0] !== 16'h0040 || wrAddrLog[1] !== 16'h0041) begin
      errors++;
      $display("[TB] FAIL midload_reload: bytes_written=%0d writes=%0d, required 2 writes at 0040 0041", bytesWritten, wrAddrLog.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    $display("[TB] timeout");
    clearLogs();
    doStart();
    sendByte(8'h00);
    sendByte(8'h02);
    repeat (16) @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_early: err=%b busy=%b at 15 idle cycles, required 0 1", err, busy);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || cpuHold !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_error: err=%b busy=%b cpu_hold=%b, required 1 0 1", err, busy, cpuHold);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || cpuHold !== 1'b1 || inReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_sticky: err=%b cpu_hold=%b in_ready=%b, required 1 1 0", err, cpuHold, inReady);
    end
    @(posedge clk); #1;
    doStart();
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_clear: err=%b busy=%b, required 0 1", err, busy);
    end
    sendByte(8'h00); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_recover: done=%b err=%b, required 1 0", done, err);
    end
    @(posedge clk); #1;
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    test_reset();
    test_basic_load();
    test_zero_length();
    test_wrap_backpressure();
    test_start_in_dwait();
    test_reset_midload();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
